// File: rtl/axi_interconnect_wr_mc.sv
// Round-robin AXI write front end: one BURST_LEN burst per grant into per-channel DDR regions; awvalid 2 cycles after synced ready.
// Holds awvalid until awready, pops the granted FIFO on wready; define AXI_WR_REGION_WRAP_EN to wrap region offsets instead of stopping.
module axi_interconnect_wr_mc #(
  parameter int         CTRL_ADDR_WIDTH = 28,
  parameter int         DQ_WIDTH        = 32,
  parameter int         BURST_LEN       = 16,
  parameter int         CH_NUM          = 2,
  parameter int         REGION_BURSTS   = 1024,
  parameter logic [7:0] CMD_START       = 8'hA1,
  parameter logic [7:0] CMD_STOP        = 8'hA2,
  parameter logic [7:0] CMD_ADDR_RST    = 8'hA0,
  localparam int        BEAT_W          = DQ_WIDTH * 8,
  localparam int        GW              = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rs232_data,
  input  logic                       rs232_flag,
  input  logic [CH_NUM-1:0]          ch_rready,
  input  logic [CH_NUM*BEAT_W-1:0]   ch_data,
  output logic [CH_NUM-1:0]          ch_rd_en,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,
  output logic [BEAT_W-1:0]          axi_wdata,
  input  logic                       axi_wready,
  input  logic                       axi_wlast,
  output logic                       record_valid,
  output logic [CH_NUM-1:0]          ch_full,
  output logic [GW-1:0]              grant_ch
);

  localparam int          ADDR_STEP    = BURST_LEN * 8;
  localparam int          OFF_W        = $clog2(REGION_BURSTS) + 1;
  localparam logic [63:0] REGION_BYTES = 64'(REGION_BURSTS) * 64'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, ARB, AWADDR, WDATA} state_t;
  state_t state, state_nxt;

  logic [CH_NUM-1:0]          rdy_meta, rdy_sync, elig;
  logic [OFF_W-1:0]           off [CH_NUM];
  logic [GW-1:0]              ptr, arb_g, idx;
  logic                       arb_found, aw_hs, cmd_addr_rst;
  logic [CTRL_ADDR_WIDTH-1:0] arb_addr;

  assign elig         = rdy_sync & ~ch_full;
  assign aw_hs        = (state == AWADDR) && axi_awready;
  assign cmd_addr_rst = rs232_flag && (rs232_data == CMD_ADDR_RST);
  assign axi_awvalid  = (state == AWADDR);

  // Scan starts one past the last winner so every channel gets a turn.
  always_comb begin
    arb_found = 1'b0;
    arb_g     = '0;
    idx       = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = GW'((int'(ptr) + i) % CH_NUM);
      if (!arb_found && elig[idx]) begin
        arb_found = 1'b1;
        arb_g     = idx;
      end
    end
    arb_addr = CTRL_ADDR_WIDTH'(64'(arb_g) * REGION_BYTES + 64'(off[arb_g]) * 64'(ADDR_STEP));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (record_valid && |elig) state_nxt = ARB;
      ARB:     state_nxt = arb_found ? AWADDR : IDLE;
      AWADDR:  if (axi_awready) state_nxt = WDATA;
      WDATA:   if (axi_wlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ch_rd_en  = '0;
    axi_wdata = '0;
    if (state == WDATA) begin
      ch_rd_en[grant_ch] = axi_wready;
      axi_wdata          = ch_data[int'(grant_ch)*BEAT_W +: BEAT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rdy_meta     <= '0;
      rdy_sync     <= '0;
      record_valid <= 1'b0;
      ch_full      <= '0;
      ptr          <= GW'(CH_NUM - 1);
      grant_ch     <= '0;
      axi_awaddr   <= '0;
      for (int c = 0; c < CH_NUM; c++) off[c] <= '0;
    end else begin
      state    <= state_nxt;
      rdy_meta <= ch_rready;
      rdy_sync <= rdy_meta;

      if (rs232_flag && rs232_data == CMD_START)     record_valid <= 1'b1;
      else if (rs232_flag && rs232_data == CMD_STOP) record_valid <= 1'b0;

      if (state == ARB && arb_found) begin
        grant_ch   <= arb_g;
        axi_awaddr <= arb_addr;
      end

      if (aw_hs) ptr <= grant_ch;

      // An address reset in the handshake cycle wins over the offset increment.
      if (cmd_addr_rst) begin
        for (int c = 0; c < CH_NUM; c++) off[c] <= '0;
        ch_full <= '0;
      end else if (aw_hs) begin
`ifdef AXI_WR_REGION_WRAP_EN
        off[grant_ch] <= (off[grant_ch] == OFF_W'(REGION_BURSTS - 1)) ? '0
                         : off[grant_ch] + OFF_W'(1);
`else
        off[grant_ch] <= off[grant_ch] + OFF_W'(1);
        if (off[grant_ch] == OFF_W'(REGION_BURSTS - 1)) ch_full[grant_ch] <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_axi_interconnect_wr_mc.sv
// Directed bench for axi_interconnect_wr_mc: main instance at default sizing, second instance with 4-burst regions.
// Both instances share all inputs, so they run in lockstep while only channel 0 is active.
module tb_axi_interconnect_wr_mc;

  logic         clk, rst;
  logic [7:0]   rs232_data;
  logic         rs232_flag;
  logic [1:0]   ch_rready;
  logic [511:0] ch_data;
  logic         axi_awready, axi_wready, axi_wlast;

  logic [1:0]   ch_rd_en, ch_full, b_ch_rd_en, b_ch_full;
  logic [27:0]  axi_awaddr, b_awaddr;
  logic         axi_awvalid, b_awvalid, record_valid, b_record_valid;
  logic [255:0] axi_wdata, b_wdata;
  logic [0:0]   grant_ch, b_grant_ch;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] START = 8'hA1, STOP = 8'hA2, ADDR_RST = 8'hA0;

  axi_interconnect_wr_mc dut (
    .clk(clk), .rst(rst), .rs232_data(rs232_data), .rs232_flag(rs232_flag),
    .ch_rready(ch_rready), .ch_data(ch_data), .ch_rd_en(ch_rd_en),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
    .record_valid(record_valid), .ch_full(ch_full), .grant_ch(grant_ch));

  axi_interconnect_wr_mc #(.REGION_BURSTS(4)) dut_small (
    .clk(clk), .rst(rst), .rs232_data(rs232_data), .rs232_flag(rs232_flag),
    .ch_rready(ch_rready), .ch_data(ch_data), .ch_rd_en(b_ch_rd_en),
    .axi_awaddr(b_awaddr), .axi_awvalid(b_awvalid), .axi_awready(axi_awready),
    .axi_wdata(b_wdata), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
    .record_valid(b_record_valid), .ch_full(b_ch_full), .grant_ch(b_grant_ch));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] pat(input logic ch, input int b);
    pat = {8{(ch ? 32'hB000_0000 : 32'hA000_0000) | 32'(b)}};
  endfunction

  task automatic apply_reset;
    rst = 1'b1; rs232_data = '0; rs232_flag = 1'b0; ch_rready = '0; ch_data = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_wlast = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    rs232_data = c; rs232_flag = 1'b1;
    @(negedge clk);
    rs232_flag = 1'b0; rs232_data = '0;
  endtask

  // Acts as the DDR side for one burst; cmd_beat<0 sends cmd_code in the AW handshake cycle.
  task automatic do_burst(input int cmd_beat, input logic [7:0] cmd_code,
                          output logic [27:0] addr, output logic gch, output int pulses,
                          output int data_err, output int other_rd, output int wait_cyc,
                          output bit b_aw_any, output logic [27:0] b_addr);
    addr = 'x; gch = 'x; pulses = 0; data_err = 0; other_rd = 0; wait_cyc = 0;
    b_aw_any = 1'b0; b_addr = 'x;
    while (axi_awvalid !== 1'b1 && wait_cyc < 100) begin
      if (b_awvalid === 1'b1) b_aw_any = 1'b1;
      @(negedge clk);
      wait_cyc++;
    end
    if (axi_awvalid !== 1'b1) return;
    addr = axi_awaddr; gch = grant_ch;
    if (b_awvalid === 1'b1) begin b_aw_any = 1'b1; b_addr = b_awaddr; end
    axi_awready = 1'b1;
    if (cmd_beat < 0) begin rs232_data = cmd_code; rs232_flag = 1'b1; end
    @(negedge clk);
    axi_awready = 1'b0; rs232_flag = 1'b0;
    for (int b = 0; b < 16; b++) begin
      ch_data = {pat(1'b1, b), pat(1'b0, b)};
      axi_wready = 1'b1; axi_wlast = (b == 15);
      if (b == cmd_beat) begin rs232_data = cmd_code; rs232_flag = 1'b1; end
      #1;
      if (ch_rd_en[gch] === 1'b1) pulses++;
      if (ch_rd_en[~gch] !== 1'b0) other_rd++;
      if (axi_wdata !== pat(gch, b)) data_err++;
      @(negedge clk);
      rs232_flag = 1'b0;
    end
    axi_wready = 1'b0; axi_wlast = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rs232_data = '0; rs232_flag = 1'b0; ch_rready = '0; ch_data = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_wlast = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL reset_awvalid: got %b want 0", axi_awvalid); end
    n_checks++; if (record_valid !== 1'b0) begin n_fail++; $display("FAIL reset_record_valid: got %b want 0", record_valid); end
    n_checks++; if (axi_awaddr !== 28'h0) begin n_fail++; $display("FAIL reset_awaddr: got %h want 0", axi_awaddr); end
    n_checks++; if (ch_rd_en !== 2'b00 || ch_full !== 2'b00) begin n_fail++; $display("FAIL reset_rd_en_full: got %b/%b want 00/00", ch_rd_en, ch_full); end
    n_checks++; if (grant_ch !== 1'b0 || axi_wdata !== 256'h0) begin n_fail++; $display("FAIL reset_grant_wdata: got %b/%h want 0/0", grant_ch, axi_wdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_channel;
    logic [27:0] exp_addr [3] = '{28'h0, 28'h80, 28'h100};
    logic [27:0] a, ba; logic g; int p, de, orr, wc, n; bit bany;
    apply_reset();
    send_cmd(START);
    ch_rready = 2'b01;
    n = 0;
    while (axi_awvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 4", n); end
    for (int k = 0; k < 3; k++) begin
      do_burst(99, 8'h00, a, g, p, de, orr, wc, bany, ba);
      n_checks++; if (a !== exp_addr[k]) begin n_fail++; $display("FAIL single_addr%0d: got %h want %h", k, a, exp_addr[k]); end
      n_checks++; if (g !== 1'b0) begin n_fail++; $display("FAIL single_grant%0d: got %b want 0", k, g); end
      n_checks++; if (p !== 16 || orr !== 0) begin n_fail++; $display("FAIL single_rd_en%0d: got %0d pulses/%0d stray want 16/0", k, p, orr); end
      n_checks++; if (de !== 0) begin n_fail++; $display("FAIL single_wdata%0d: got %0d bad beats want 0", k, de); end
    end
  endtask

  task automatic test_round_robin;
    logic [27:0] exp_addr [4] = '{28'h0, 28'h20000, 28'h80, 28'h20080};
    logic        exp_g    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [27:0] a, ba; logic g; int p, de, orr, wc; bit bany;
    apply_reset();
    send_cmd(START);
    ch_rready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      do_burst(99, 8'h00, a, g, p, de, orr, wc, bany, ba);
      n_checks++; if (a !== exp_addr[k]) begin n_fail++; $display("FAIL rr_addr%0d: got %h want %h", k, a, exp_addr[k]); end
      n_checks++; if (g !== exp_g[k]) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, g, exp_g[k]); end
      n_checks++; if (p !== 16 || orr !== 0 || de !== 0) begin n_fail++; $display("FAIL rr_beats%0d: got %0d/%0d/%0d want 16/0/0", k, p, orr, de); end
      if (k > 0) begin
        n_checks++; if (wc !== 2) begin n_fail++; $display("FAIL rr_gap%0d: got %0d idle cycles want 2", k, wc); end
      end
    end
  endtask

  task automatic test_stop_mid_burst;
    logic [27:0] a, ba; logic g; int p, de, orr, wc, seen; bit bany;
    apply_reset();
    send_cmd(START);
    ch_rready = 2'b11;
    do_burst(4, STOP, a, g, p, de, orr, wc, bany, ba);
    n_checks++; if (p !== 16 || a !== 28'h0) begin n_fail++; $display("FAIL stop_burst_done: got %0d pulses addr %h want 16 addr 0", p, a); end
    n_checks++; if (record_valid !== 1'b0) begin n_fail++; $display("FAIL stop_record_valid: got %b want 0", record_valid); end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (axi_awvalid !== 1'b0 || ch_rd_en !== 2'b00) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL stop_hold_idle: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_addr_reset;
    logic [27:0] a, ba; logic g; int p, de, orr, wc; bit bany;
    apply_reset();
    send_cmd(START);
    ch_rready = 2'b01;
    do_burst(99, 8'h00, a, g, p, de, orr, wc, bany, ba);
    do_burst(3, ADDR_RST, a, g, p, de, orr, wc, bany, ba);
    n_checks++; if (a !== 28'h80) begin n_fail++; $display("FAIL arst_inflight: got %h want 80", a); end
    do_burst(-1, ADDR_RST, a, g, p, de, orr, wc, bany, ba);
    n_checks++; if (a !== 28'h0) begin n_fail++; $display("FAIL arst_next: got %h want 0", a); end
    do_burst(99, 8'h00, a, g, p, de, orr, wc, bany, ba);
    n_checks++; if (a !== 28'h0) begin n_fail++; $display("FAIL arst_beats_handshake: got %h want 0", a); end
  endtask

  task automatic test_region_end;
    logic [27:0] a, ba; logic g; int p, de, orr, wc; bit bany;
    apply_reset();
    send_cmd(START);
    ch_rready = 2'b01;
    for (int k = 0; k < 4; k++) do_burst(99, 8'h00, a, g, p, de, orr, wc, bany, ba);
    n_checks++; if (ba !== 28'h180) begin n_fail++; $display("FAIL region_4th_addr: got %h want 180", ba); end
    n_checks++; if (ch_full !== 2'b00) begin n_fail++; $display("FAIL region_big_full: got %b want 00", ch_full); end
    do_burst(99, 8'h00, a, g, p, de, orr, wc, bany, ba);
    n_checks++; if (a !== 28'h200) begin n_fail++; $display("FAIL region_big_5th: got %h want 200", a); end
`ifdef AXI_WR_REGION_WRAP_EN
    n_checks++; if (b_ch_full !== 2'b00) begin n_fail++; $display("FAIL region_wrap_full: got %b want 00", b_ch_full); end
    n_checks++; if (bany !== 1'b1 || ba !== 28'h0) begin n_fail++; $display("FAIL region_wrap_5th: got aw %b addr %h want 1 addr 0", bany, ba); end
`else
    n_checks++; if (b_ch_full !== 2'b01) begin n_fail++; $display("FAIL region_full: got %b want 01", b_ch_full); end
    n_checks++; if (bany !== 1'b0) begin n_fail++; $display("FAIL region_no_5th: got awvalid %b want 0", bany); end
`endif
  endtask

  task automatic test_reset_mid_burst;
    logic [27:0] a, ba; logic g; int p, de, orr, wc, n; bit bany;
    apply_reset();
    send_cmd(START);
    ch_rready = 2'b11;
    do_burst(99, 8'h00, a, g, p, de, orr, wc, bany, ba);
    n = 0;
    while (axi_awvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (axi_awvalid !== 1'b1 || grant_ch !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending: got awvalid %b grant %b want 1/1", axi_awvalid, grant_ch); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (axi_awvalid !== 1'b0 || record_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop: got awvalid %b record %b want 0/0", axi_awvalid, record_valid); end
    rst = 1'b0;
    send_cmd(START);
    do_burst(99, 8'h00, a, g, p, de, orr, wc, bany, ba);
    n_checks++; if (g !== 1'b0 || a !== 28'h0) begin n_fail++; $display("FAIL rstmid_first_grant: got ch %b addr %h want 0/0", g, a); end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_stop_mid_burst();
    test_addr_reset();
    test_region_end();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
